gopf_mul_scheduler: RTL and testbench
=====================================

Name: gopf_mul_scheduler

Overview:
- Shares one registered GF(2^M) constant multiplier among N requesters in the GOPF_EVAL datapath.
- Each job supplies an operand and an iteration count ITER. The block multiplies the operand by the constant ITER times by looping the multiplier output back to its input, then returns the result tagged with the requester ID.
- Used for repeated constant scaling during Goppa-polynomial evaluation.
- Processes one job at a time; arbitration is round-robin.

Parameters:
- M, 16, field width; must equal the multiplier's m.
- N, 4, number of requesters (2..16).
- ITW, 4, width of the iteration count.
- MUL_LAT, 1, multiplier latency in cycles from mul_a stable to mul_c valid (>=1).
- IDW, 2, requester ID width; equals clog2(N).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester job valid; the requester holds it and its data stable until accepted.
- req_data  in  N*M  operands; requester i uses slice [i*M +: M].
- req_iter  in  N*ITW  iteration counts; requester i uses slice [i*ITW +: ITW].
- req_ready  out  N  one-hot accept; a job transfers when req_valid[i] and req_ready[i] are both high.
- mul_a  out  M  registered operand to the multiplier; bit i is the x^i coefficient.
- mul_c  in  M  multiplier result.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  M  result.
- rsp_id  out  IDW  index of the requester that owns the result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, mul_a=0, it_cnt=0, lat_cnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=N-1 (so requester 0 has highest priority after reset), busy=0. req_ready is combinational and therefore 0 outside IDLE.
- mul_a always equals acc. acc changes only on load or capture.
- States and transitions:
  - IDLE: grant = first i with req_valid[i], searching from (rr_ptr+1) mod N with wrap-around. req_ready = onehot(grant), only while in IDLE. On transfer: acc<=req_data[g], it_cnt<=req_iter[g], rsp_id<=g, rr_ptr<=g. Next state is DONE if req_iter[g]==0, otherwise ISSUE. With no valid request, stay in IDLE and assert no req_ready.
  - ISSUE: one cycle with mul_a stable; lat_cnt<=MUL_LAT; go to WAIT.
  - WAIT: decrement lat_cnt each cycle. In the cycle where lat_cnt==1: acc<=mul_c and it_cnt<=it_cnt-1. Then go to DONE if it_cnt==1, otherwise ISSUE.
  - DONE: rsp_valid=1 and rsp_data=acc, both held until rsp_ready. On rsp_valid && rsp_ready, go to IDLE with rsp_valid=0. The result is held indefinitely under backpressure.
- Latency: rsp_valid first rises ITER*(1+MUL_LAT)+1 cycles after the accept cycle.
- Throughput:
  - No new request is accepted before the cycle after the response handshake, so the minimum accept-to-accept spacing is ITER*(1+MUL_LAT)+2 cycles.
  - ITER=0 returns the operand unchanged and does not use the multiplier.
  - ITER=2^ITW-1 is legal.
- Fairness: a requester that stays valid is granted within N jobs.
- Requests:
  - Deasserting req_valid before acceptance is legal; that request is simply not granted.
  - Requests arriving while busy wait; they are not dropped.
- Simultaneous events: when rsp_ready and new req_valid coincide in DONE, the request is not accepted in that cycle. It is accepted in the following IDLE cycle.
- Reset mid-operation: the in-flight job is discarded, all registers return to their reset values immediately, and no response is produced.
- Width rules:
  - acc, mul_a, rsp_data are M bits.
  - it_cnt is ITW bits and never underflows, because the ITER=0 path bypasses the counter.
  - lat_cnt is clog2(MUL_LAT+1) bits.

Test Plan:
- Single job: bench uses the real multiplier, MUL_LAT=1. Requester 2 sends operand x^0 with ITER=1 -> rsp_valid rises 3 cycles after accept; rsp_data has ones exactly at coefficients {0,2,4,6,10,13,15}; rsp_id=2.
- ITER=0: requester 1 sends operand 0x1234 with ITER=0 -> rsp_data=0x1234 one cycle after accept; mul_a is never updated with a new value during the job.
- Round-robin: requesters 0-3 all held valid from reset, each with ITER=1 -> accept order 0,1,2,3,0; every rsp_id matches its job.
- Backpressure: rsp_ready held low for 10 cycles in DONE -> rsp_valid and rsp_data stable throughout, req_ready stays 0, the job completes on rsp_ready=1.
- Iteration chain: operand x^0, ITER=3 -> rsp_valid rises 7 cycles after accept; result equals the model c^3 mod (x^16+x^5+x^3+x^2+1); mul_a changes exactly 3 times.
- Reset mid-job: rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously with no rsp_valid pulse; the next request after reset is granted starting from requester 0.

Source files
------------

// File: rtl/gopf_mul_scheduler_if.sv
// Bundle between the shared GF(2^M) constant-multiplier scheduler, its requesters,
// the external multiplier and the result consumer.
interface gopf_mul_scheduler_if #(
    parameter int M   = 16,
    parameter int N   = 4,
    parameter int ITW = 4,
    parameter int IDW = 2
);
    // Handshakes: a job moves when req_valid[i] && req_ready[i] on a rising clk edge;
    // a result moves when rsp_valid && rsp_ready. A valid holder keeps its data
    // stable until the transfer; the scheduler holds rsp_valid/rsp_data until accepted.
    logic [N-1:0]     req_valid;
    logic [N*M-1:0]   req_data;
    logic [N*ITW-1:0] req_iter;
    logic [N-1:0]     req_ready;
    logic [M-1:0]     mul_a;
    logic [M-1:0]     mul_c;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [M-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             busy;
    logic [1:0]       dbg_state;

    modport master (
        output req_valid, req_data, req_iter, mul_c, rsp_ready,
        input  req_ready, mul_a, rsp_valid, rsp_data, rsp_id, busy, dbg_state
    );

    modport slave (
        input  req_valid, req_data, req_iter, mul_c, rsp_ready,
        output req_ready, mul_a, rsp_valid, rsp_data, rsp_id, busy, dbg_state
    );
endinterface

// File: rtl/gopf_mul_scheduler.sv
// Round-robin scheduler sharing one registered GF(2^M) constant multiplier: each job
// loops its operand through the multiplier ITER times and returns the tagged result.
module gopf_mul_scheduler #(
    parameter int M       = 16,
    parameter int N       = 4,
    parameter int ITW     = 4,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 2
) (
    input logic                clk,
    input logic                rst_n,
    gopf_mul_scheduler_if.slave bus
);
    localparam int LW = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [M-1:0]    r_acc;
    logic [ITW-1:0]  r_it_cnt;
    logic [LW-1:0]   r_lat_cnt;
    logic            r_rsp_valid;
    logic [M-1:0]    r_rsp_data;
    logic [IDW-1:0]  r_rsp_id;
    logic [IDW-1:0]  r_rr_ptr;

    logic            w_found;
    logic [IDW-1:0]  w_grant;
    logic [IDW-1:0]  w_cand;
    logic [M-1:0]    w_grant_data;
    logic [ITW-1:0]  w_grant_iter;
    logic [N-1:0]    w_req_ready;

    // Search starts one past the last winner so every valid requester is served within N jobs.
    always_comb begin
        w_found      = 1'b0;
        w_grant      = '0;
        w_cand       = '0;
        w_grant_data = '0;
        w_grant_iter = '0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDW'((int'(r_rr_ptr) + 1 + k) % N);
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found = 1'b1;
                w_grant = w_cand;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (w_grant == IDW'(k)) begin
                w_grant_data = bus.req_data[k*M +: M];
                w_grant_iter = bus.req_iter[k*ITW +: ITW];
            end
        end
    end

    assign w_req_ready   = (r_state == S_IDLE && w_found) ? (N'(1) << w_grant) : '0;
    assign bus.req_ready = w_req_ready;
    assign bus.mul_a     = r_acc;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_it_cnt    <= '0;
            r_lat_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_id    <= '0;
            r_rr_ptr    <= IDW'(N - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_acc    <= w_grant_data;
                        r_it_cnt <= w_grant_iter;
                        r_rsp_id <= w_grant;
                        r_rr_ptr <= w_grant;
                        // ITER=0 skips the multiplier, so it_cnt is never decremented from zero.
                        if (w_grant_iter == '0) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= w_grant_data;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_lat_cnt <= LW'(MUL_LAT);
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    r_lat_cnt <= r_lat_cnt - LW'(1);
                    if (r_lat_cnt == LW'(1)) begin
                        r_acc    <= bus.mul_c;
                        r_it_cnt <= r_it_cnt - ITW'(1);
                        if (r_it_cnt == ITW'(1)) begin
                            r_state     <= S_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= bus.mul_c;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gopf_mul_scheduler.sv
// Directed bench for gopf_mul_scheduler with a registered GF(2^16) constant multiplier
// (constant 0xA455, modulus x^16+x^5+x^3+x^2+1) closing the loop.
module tb_gopf_mul_scheduler;
    localparam int M       = 16;
    localparam int N       = 4;
    localparam int ITW     = 4;
    localparam int MUL_LAT = 1;
    localparam int IDW     = 2;
    localparam logic [15:0] C_MUL    = 16'hA455;
    localparam logic [15:0] POLY_LOW = 16'h002D;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic [M-1:0]   exp_q[$];
    logic [IDW-1:0] id_q[$];

    gopf_mul_scheduler_if #(.M(M), .N(N), .ITW(ITW), .IDW(IDW)) bus ();

    gopf_mul_scheduler #(.M(M), .N(N), .ITW(ITW), .MUL_LAT(MUL_LAT), .IDW(IDW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] p  = '0;
        logic [15:0] aa = a;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) p ^= aa;
            aa = aa[15] ? ((aa << 1) ^ POLY_LOW) : (aa << 1);
        end
        return p;
    endfunction

    // Registered multiplier, one cycle from mul_a to mul_c.
    always @(posedge clk) bus.mul_c <= gf_mul(bus.mul_a, C_MUL);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input int id, input logic [15:0] data, input logic [3:0] iter);
        bus.req_data[id*M +: M]     = data;
        bus.req_iter[id*ITW +: ITW] = iter;
        bus.req_valid[id]           = 1'b1;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.rsp_valid && cycles < 64);
    endtask

    task automatic complete_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h0) begin failures++; $display("FAIL reset_rsp_data got=%0h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0h exp=0", bus.rsp_id); end
        checks++; if (bus.mul_a !== 16'h0) begin failures++; $display("FAIL reset_mul_a got=%0h exp=0", bus.mul_a); end
        checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0h exp=0", bus.dbg_state); end
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%0b exp=0000", bus.req_ready); end
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) drive_req(i, 16'h0001, 4'd1);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL reset_first_grant got=%0b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL withdrawn_req_busy got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_single();
        int c;
        drive_req(2, 16'h0001, 4'd1);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%0b exp=0100", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_rsp(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", c); end
        checks++; if (bus.rsp_data !== 16'hA455) begin failures++; $display("FAIL single_data got=%0h exp=a455", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d exp=2", bus.rsp_id); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%0h exp=1", bus.busy); end
        complete_rsp();
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL single_rsp_drop got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%0h exp=0", bus.busy); end
    endtask

    task automatic test_iter0();
        int c;
        drive_req(1, 16'h1234, 4'd0);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL iter0_grant got=%0b exp=0010", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_rsp(c);
        checks++; if (c !== 1) begin failures++; $display("FAIL iter0_latency got=%0d exp=1", c); end
        checks++; if (bus.rsp_data !== 16'h1234) begin failures++; $display("FAIL iter0_data got=%0h exp=1234", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd1) begin failures++; $display("FAIL iter0_id got=%0d exp=1", bus.rsp_id); end
        repeat (3) begin
            checks++; if (bus.mul_a !== 16'h1234) begin failures++; $display("FAIL iter0_mul_a got=%0h exp=1234", bus.mul_a); end
            @(negedge clk);
        end
        complete_rsp();
    endtask

    task automatic test_chain();
        int c;
        int changes;
        logic [15:0] prev;
        logic [15:0] e;
        exp_q.push_back(gf_mul(gf_mul(C_MUL, C_MUL), C_MUL));
        drive_req(0, 16'h0001, 4'd3);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL chain_grant got=%0b exp=0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        prev    = bus.mul_a;
        c       = 0;
        changes = 0;
        do begin
            @(negedge clk);
            c++;
            if (bus.mul_a !== prev) changes++;
            prev = bus.mul_a;
        end while (!bus.rsp_valid && c < 64);
        e = exp_q.pop_front();
        checks++; if (c !== 7) begin failures++; $display("FAIL chain_latency got=%0d exp=7", c); end
        checks++; if (changes !== 3) begin failures++; $display("FAIL chain_mul_a_changes got=%0d exp=3", changes); end
        checks++; if (bus.rsp_data !== e) begin failures++; $display("FAIL chain_data got=%0h exp=%0h", bus.rsp_data, e); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL chain_id got=%0d exp=0", bus.rsp_id); end
        complete_rsp();
    endtask

    task automatic test_round_robin();
        int c;
        logic [IDW-1:0] e;
        logic [3:0] exp_rdy;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) drive_req(i, 16'h0001, 4'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        id_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int j = 0; j < 5; j++) begin
            e       = id_q.pop_front();
            exp_rdy = 4'b0001 << e;
            checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL rr_grant job=%0d got=%0b exp=%0b", j, bus.req_ready, exp_rdy); end
            @(posedge clk);
            wait_rsp(c);
            checks++; if (c !== 3) begin failures++; $display("FAIL rr_latency job=%0d got=%0d exp=3", j, c); end
            checks++; if (bus.rsp_id !== e) begin failures++; $display("FAIL rr_id job=%0d got=%0d exp=%0d", j, bus.rsp_id, e); end
            checks++; if (bus.rsp_data !== 16'hA455) begin failures++; $display("FAIL rr_data job=%0d got=%0h exp=a455", j, bus.rsp_data); end
            checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL rr_ready_in_done job=%0d got=%0b exp=0000", j, bus.req_ready); end
            complete_rsp();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        int c;
        drive_req(3, 16'h0002, 4'd1);
        drive_req(0, 16'h0005, 4'd0);
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL bp_grant got=%0b exp=1000", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid[3] = 1'b0;
        wait_rsp(c);
        checks++; if (c !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", c); end
        repeat (10) begin
            checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_hold got=%0h exp=1", bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 16'h4887) begin failures++; $display("FAIL bp_data_hold got=%0h exp=4887", bus.rsp_data); end
            checks++; if (bus.rsp_id !== 2'd3) begin failures++; $display("FAIL bp_id_hold got=%0d exp=3", bus.rsp_id); end
            checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready_hold got=%0b exp=0000", bus.req_ready); end
            @(negedge clk);
        end
        complete_rsp();
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL bp_wrap_grant got=%0b exp=0001", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_rsp(c);
        checks++; if (c !== 1) begin failures++; $display("FAIL bp_wrap_latency got=%0d exp=1", c); end
        checks++; if (bus.rsp_data !== 16'h0005) begin failures++; $display("FAIL bp_wrap_data got=%0h exp=5", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL bp_wrap_id got=%0d exp=0", bus.rsp_id); end
        complete_rsp();
    endtask

    task automatic test_reset_mid();
        int  c;
        bit  seen;
        drive_req(2, 16'h0001, 4'd3);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant got=%0b exp=0100", bus.req_ready); end
        @(posedge clk);
        #1 bus.req_valid = '0;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.dbg_state !== 2'd2 && c < 20);
        checks++; if (bus.dbg_state !== 2'd2) begin failures++; $display("FAIL rmid_reach_wait got=%0d exp=2", bus.dbg_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%0h exp=0", bus.busy); end
        checks++; if (bus.mul_a !== 16'h0) begin failures++; $display("FAIL rmid_mul_a got=%0h exp=0", bus.mul_a); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_rsp_valid got=%0h exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h0) begin failures++; $display("FAIL rmid_rsp_data got=%0h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL rmid_rsp_id got=%0d exp=0", bus.rsp_id); end
        checks++; if (bus.dbg_state !== 2'd0) begin failures++; $display("FAIL rmid_state got=%0d exp=0", bus.dbg_state); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rmid_no_rsp got=%0h exp=0", seen); end
        for (int i = 0; i < N; i++) drive_req(i, 16'h0001, 4'd1);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL rmid_next_grant got=%0b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_iter  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_iter0();
        test_chain();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
